exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL provide port syscall, input, 1 bit: the current instruction is SYSCALL.
REQ-005 SHALL provide port brk, input, 1 bit: the current instruction is BREAK.
REQ-006 SHALL provide port teq_ins, input, 1 bit: the current instruction is TEQ.
REQ-007 SHALL provide port teq_eq, input, 1 bit: the TEQ operands compare equal.
REQ-008 SHALL provide port eret_ins, input, 1 bit: the current instruction is ERET.
REQ-009 SHALL provide port ie, input, 1 bit: CP0 Status interrupt-enable bit.
REQ-010 SHALL provide port pc, input, 32 bits: PC of the current instruction.
REQ-011 SHALL provide port exc_req, output, 1 bit: exception strobe driven into CP0 (its teq input).
REQ-012 SHALL provide port eret_out, output, 1 bit: return strobe driven into CP0 (its eret input).
REQ-013 SHALL provide port cause, output, 5 bits: exception code driven to CP0.
REQ-014 SHALL provide port epc, output, 32 bits: faulting PC driven to CP0 (its pc input).
REQ-015 SHALL provide port busy, output, 1 bit: a handler is active.
REQ-016 SHALL provide port stall, output, 1 bit: a one-cycle PC-redirect bubble.
REQ-017 SHALL provide, with EXC_STAT_EN only, port cnt_sel, input, 2 bits: counter select.
REQ-018 SHALL provide, with EXC_STAT_EN only, port cnt_data, output, CNT_W bits: the selected counter value.

Function
REQ-019 SHALL recognise a qualified event as brk | syscall | (teq_ins & teq_eq).
REQ-020 SHALL use cause codes BREAK=5'b01001, SYSCALL=5'b01000, TEQ=5'b01101.
REQ-021 SHALL resolve simultaneous events by priority BREAK > SYSCALL > TEQ.
REQ-022 SHALL implement a four-state FSM with states IDLE, TRAP, HANDLER and RET.
REQ-023 SHALL, in IDLE, on a qualified event with ie=1 at edge N: register cause and epc=pc, then hold exc_req=1 for exactly the cycle after edge N, in state TRAP.
REQ-024 SHALL, in IDLE, drop a qualified event when ie=0: no state change, no exc_req, and the dropped count increments.
REQ-025 SHALL ignore eret_ins in IDLE; eret_out stays 0.
REQ-026 SHALL go unconditionally from TRAP to HANDLER on the next edge.
REQ-027 SHALL hold busy=1 in TRAP, HANDLER and RET.
REQ-028 SHALL, in HANDLER, drop any qualified event (no nesting) and increment the dropped count.
REQ-029 SHALL, in HANDLER, go to RET on eret_ins; in RET, eret_out=1 for exactly one cycle, then return to IDLE.
REQ-030 SHALL, when eret_ins and a qualified event coincide in HANDLER, let eret win and count the event as dropped.
REQ-031 SHALL assert stall only in TRAP and RET.
REQ-032 SHALL drive all outputs from registers, with no combinational path from inputs to exc_req, eret_out, cause or epc.
REQ-033 SHALL hold cause and epc stable from TRAP until the next accepted exception; they SHALL NOT change in HANDLER or RET.

Reset
REQ-034 SHALL, while rst=0 at a rising edge, enter IDLE with exc_req=0, eret_out=0, cause=0, epc=0, busy=0, stall=0 and all counters 0.
REQ-035 SHALL abort on reset asserted mid-operation (TRAP, HANDLER or RET) with no further strobes.

Configuration
REQ-036 SHALL, with macro EXC_STAT_EN defined, include four saturating counters of CNT_W bits each, selected by cnt_sel:
- 0: accepted SYSCALL exceptions.
- 1: accepted BREAK exceptions.
- 2: accepted TEQ exceptions.
- 3: dropped events.
REQ-037 SHALL, with EXC_STAT_EN defined, update counters on the edge that samples the event, saturate at all-ones without wrapping, and return cnt_data combinationally from cnt_sel.
REQ-038 SHALL, without EXC_STAT_EN, have no cnt_sel or cnt_data ports and no counter logic; FSM behaviour is identical.

Verification
REQ-039 SHALL verify SYSCALL: ie=1, syscall=1, pc=3 -> next cycle exc_req=1, cause=01000, epc=3, stall=1; then busy=1 held.
REQ-040 SHALL verify masking: ie=0, teq_ins=1, teq_eq=1, pc=1 -> exc_req stays 0, FSM stays IDLE, cnt_sel=3 gives 1.
REQ-041 SHALL verify TEQ not-equal and priority:
- teq_ins=1, teq_eq=0 -> no exception.
- Then brk=1, syscall=1 together with pc=4 -> cause=01001, epc=4.
REQ-042 SHALL verify return and nesting: in HANDLER, syscall=1 with pc=9 -> ignored, epc stays at its prior value; eret_ins=1 -> eret_out=1 for one cycle, stall=1, then IDLE with busy=0.
REQ-043 SHALL verify reset: rst=0 during TRAP -> next edge all outputs 0 and state IDLE; rst=1 with no events -> remains IDLE.
REQ-044 SHALL verify saturation (EXC_STAT_EN, CNT_W=2): four accepted BREAK exceptions -> cnt_sel=1 gives 2'b11.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: trap/return sequencer sitting in front of CP0.
// Turns BREAK / SYSCALL / taken TEQ into a one-cycle exception strobe with
// a latched cause and faulting PC, then waits for ERET and emits a one-cycle
// return strobe. Nested events during a handler are dropped.
// Optional macro EXC_STAT_EN adds four saturating statistics counters
// (accepted SYSCALL, accepted BREAK, accepted TEQ, dropped) read via cnt_sel.
//
// Handshake note: there is no backpressure. Event inputs are sampled on
// every rising edge; exc_req and eret_out are single-cycle strobes that the
// consumer must take in the cycle they are high.
module exc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic        brk,
    input  logic        teq_ins,
    input  logic        teq_eq,
    input  logic        eret_ins,
    input  logic        ie,
    input  logic [31:0] pc,
    output logic        exc_req,
    output logic        eret_out,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic        busy,
    output logic        stall,
    output logic [1:0]  state_dbg
`ifdef EXC_STAT_EN
    ,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_data
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        HANDLER = 2'd2,
        RET     = 2'd3
    } exc_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    exc_state_t state, state_next;
    logic       event_q;
    logic       accept;
    logic       drop;
    logic [4:0] cause_next;

    assign event_q = brk | syscall | (teq_ins & teq_eq);
    assign state_dbg = state;

    // Next-state decode plus accept/drop qualification of the sampled event.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (event_q && ie) begin
                    accept     = 1'b1;
                    state_next = TRAP;
                end else if (event_q) begin
                    drop = 1'b1;
                end
            end
            TRAP:    state_next = HANDLER;
            HANDLER: begin
                // ERET wins over a coincident event, which is counted as dropped.
                drop = event_q;
                if (eret_ins) state_next = RET;
            end
            RET:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Priority encode of the exception code: BREAK > SYSCALL > TEQ.
    always_comb begin
        cause_next = CAUSE_TEQ;
        if (brk)          cause_next = CAUSE_BREAK;
        else if (syscall) cause_next = CAUSE_SYSCALL;
    end

    // State register and registered outputs; cause/epc only move on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            exc_req  <= 1'b0;
            eret_out <= 1'b0;
            busy     <= 1'b0;
            stall    <= 1'b0;
            cause    <= 5'd0;
            epc      <= 32'd0;
        end else begin
            state    <= state_next;
            exc_req  <= (state_next == TRAP);
            eret_out <= (state_next == RET);
            busy     <= (state_next != IDLE);
            stall    <= (state_next == TRAP) || (state_next == RET);
            if (accept) begin
                cause <= cause_next;
                epc   <= pc;
            end
        end
    end

`ifdef EXC_STAT_EN
    cnt_t cnt_sys, cnt_brk, cnt_teq, cnt_drop;

    // Saturating statistics counters, updated on the edge that samples the event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_sys  <= '0;
            cnt_brk  <= '0;
            cnt_teq  <= '0;
            cnt_drop <= '0;
        end else begin
            if (accept && cause_next == CAUSE_SYSCALL && cnt_sys != '1) cnt_sys <= cnt_sys + 1'b1;
            if (accept && cause_next == CAUSE_BREAK   && cnt_brk != '1) cnt_brk <= cnt_brk + 1'b1;
            if (accept && cause_next == CAUSE_TEQ     && cnt_teq != '1) cnt_teq <= cnt_teq + 1'b1;
            if (drop && cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
        end
    end

    // Combinational read mux for the selected counter.
    always_comb begin
        cnt_data = cnt_drop;
        case (cnt_sel)
            2'd0:    cnt_data = cnt_sys;
            2'd1:    cnt_data = cnt_brk;
            2'd2:    cnt_data = cnt_teq;
            default: cnt_data = cnt_drop;
        endcase
    end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl (counters built with CNT_W=2).
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall, brk, teq_ins, teq_eq, eret_ins, ie;
    logic [31:0] pc;
    logic        exc_req, eret_out, busy, stall;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [1:0]  state_dbg;
`ifdef EXC_STAT_EN
    logic [1:0]  cnt_sel;
    logic [1:0]  cnt_data;
`endif

    int errors = 0;
    int checks = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    exc_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .syscall(syscall), .brk(brk),
        .teq_ins(teq_ins), .teq_eq(teq_eq), .eret_ins(eret_ins), .ie(ie),
        .pc(pc), .exc_req(exc_req), .eret_out(eret_out), .cause(cause),
        .epc(epc), .busy(busy), .stall(stall), .state_dbg(state_dbg)
`ifdef EXC_STAT_EN
        , .cnt_sel(cnt_sel), .cnt_data(cnt_data)
`endif
    );

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ins();
        syscall = 0; brk = 0; teq_ins = 0; teq_eq = 0; eret_ins = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // state, exc_req, eret_out, busy, stall in one call
    task automatic check_ctl(input string tag, input logic [1:0] st, input logic er,
                             input logic eo, input logic bz, input logic sl);
        check({tag, ".state"}, {30'd0, state_dbg}, {30'd0, st});
        check({tag, ".exc_req"}, {31'd0, exc_req}, {31'd0, er});
        check({tag, ".eret_out"}, {31'd0, eret_out}, {31'd0, eo});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, sl});
    endtask

`ifdef EXC_STAT_EN
    task automatic check_cnt(input string tag, input logic [1:0] sel, input logic [1:0] exp);
        cnt_sel = sel;
        #1;
        check(tag, {30'd0, cnt_data}, {30'd0, exp});
    endtask
`endif

    initial begin
        rst = 0; ie = 0; pc = 0;
        clear_ins();
`ifdef EXC_STAT_EN
        cnt_sel = 0;
`endif
        // Reset state
        step(); step();
        check_ctl("reset", 2'd0, 0, 0, 0, 0);
        check("reset.cause", {27'd0, cause}, 32'd0);
        check("reset.epc", epc, 32'd0);
`ifdef EXC_STAT_EN
        check_cnt("reset.cnt0", 2'd0, 2'd0);
        check_cnt("reset.cnt3", 2'd3, 2'd0);
`endif
        rst = 1;
        step();

        // Masked TEQ: dropped
        ie = 0; teq_ins = 1; teq_eq = 1; pc = 1;
        step();
        clear_ins();
        check_ctl("mask", 2'd0, 0, 0, 0, 0);
`ifdef EXC_STAT_EN
        check_cnt("mask.dropped", 2'd3, 2'd1);
`endif

        // SYSCALL accepted
        ie = 1; syscall = 1; pc = 3;
        step();
        clear_ins();
        check_ctl("sys.trap", 2'd1, 1, 0, 1, 1);
        check("sys.cause", {27'd0, cause}, 32'h08);
        check("sys.epc", epc, 32'd3);
        step();
        check_ctl("sys.handler", 2'd2, 0, 0, 1, 0);
        check("sys.cause_hold", {27'd0, cause}, 32'h08);

        // Nested SYSCALL in HANDLER: ignored
        syscall = 1; pc = 9;
        step();
        clear_ins();
        check_ctl("nest", 2'd2, 0, 0, 1, 0);
        check("nest.epc", epc, 32'd3);
`ifdef EXC_STAT_EN
        check_cnt("nest.dropped", 2'd3, 2'd2);
        check_cnt("sys.count", 2'd0, 2'd1);
`endif

        // ERET
        eret_ins = 1;
        step();
        clear_ins();
        check_ctl("eret.ret", 2'd3, 0, 1, 1, 1);
        check("eret.epc", epc, 32'd3);
        step();
        check_ctl("eret.idle", 2'd0, 0, 0, 0, 0);

        // ERET in IDLE ignored
        eret_ins = 1;
        step();
        clear_ins();
        check_ctl("idle_eret", 2'd0, 0, 0, 0, 0);

        // TEQ not equal: no exception
        teq_ins = 1; teq_eq = 0; pc = 2;
        step();
        clear_ins();
        check_ctl("teq_ne", 2'd0, 0, 0, 0, 0);

        // BREAK + SYSCALL together: BREAK wins
        brk = 1; syscall = 1; pc = 4;
        step();
        clear_ins();
        check_ctl("prio.trap", 2'd1, 1, 0, 1, 1);
        check("prio.cause", {27'd0, cause}, 32'h09);
        check("prio.epc", epc, 32'd4);
        step();

        // ERET and event together in HANDLER: ERET wins, event dropped
        eret_ins = 1; syscall = 1; pc = 7;
        step();
        clear_ins();
        check_ctl("coinc.ret", 2'd3, 0, 1, 1, 1);
        check("coinc.epc", epc, 32'd4);
        check("coinc.cause", {27'd0, cause}, 32'h09);
`ifdef EXC_STAT_EN
        check_cnt("coinc.dropped", 2'd3, 2'd3);
`endif
        step();
        check_ctl("coinc.idle", 2'd0, 0, 0, 0, 0);

        // Taken TEQ, then reset in TRAP
        teq_ins = 1; teq_eq = 1; pc = 32'h20;
        step();
        clear_ins();
        check_ctl("teq.trap", 2'd1, 1, 0, 1, 1);
        check("teq.cause", {27'd0, cause}, 32'h0d);
        check("teq.epc", epc, 32'h20);
`ifdef EXC_STAT_EN
        check_cnt("teq.count", 2'd2, 2'd1);
        check_cnt("brk.count", 2'd1, 2'd1);
`endif
        rst = 0;
        step();
        check_ctl("rst_mid", 2'd0, 0, 0, 0, 0);
        check("rst_mid.cause", {27'd0, cause}, 32'd0);
        check("rst_mid.epc", epc, 32'd0);
`ifdef EXC_STAT_EN
        check_cnt("rst_mid.cnt2", 2'd2, 2'd0);
`endif
        rst = 1;
        step();
        check_ctl("rst_release", 2'd0, 0, 0, 0, 0);
        step();
        check_ctl("rst_quiet", 2'd0, 0, 0, 0, 0);

        // Four BREAK exceptions: counter saturates at 2'b11
        for (int i = 0; i < 4; i++) begin
            brk = 1; ie = 1; pc = 32'h100 + i;
            step();
            clear_ins();
            check("sat.exc_req", {31'd0, exc_req}, 32'd1);
            check("sat.epc", epc, 32'h100 + i);
            step();
            eret_ins = 1;
            step();
            clear_ins();
            step();
        end
        check_ctl("sat.idle", 2'd0, 0, 0, 0, 0);
`ifdef EXC_STAT_EN
        check_cnt("sat.brk", 2'd1, 2'b11);
        check_cnt("sat.dropped", 2'd3, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
